// File: rtl/write_back_pkg.sv
// Shared types and constants for the write-back stage and its load aligner.
package write_back_pkg;

    localparam int unsigned cXLEN       = 32;
    localparam int unsigned cRegSelBitW = 5;

    typedef struct packed {
        logic                   en;
        logic [cRegSelBitW-1:0] addr;
    } tRegControl;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_PC4,
        WB_LOAD
    } tWbSel;

    // funct3 encodings of the load instructions
    localparam logic [2:0] cLdB  = 3'b000;
    localparam logic [2:0] cLdH  = 3'b001;
    localparam logic [2:0] cLdW  = 3'b010;
    localparam logic [2:0] cLdBu = 3'b100;
    localparam logic [2:0] cLdHu = 3'b101;

    typedef struct packed {
        logic [cRegSelBitW-1:0] rdAddr;
        tWbSel                  wbSel;
        logic [2:0]             ldType;
        logic [1:0]             byteOff;
    } tWbInfo;

    typedef enum logic {
        StIdle,
        StWaitLoad
    } wb_state_e;

endpackage

// File: rtl/write_back_load_align.sv
// Combinational load aligner: picks the byte/half addressed by byte_off_i from
// a word-aligned memory word and sign- or zero-extends it to XLEN.
module write_back_load_align
    import write_back_pkg::*;
#(
    parameter int unsigned XLEN = cXLEN
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [2:0]      ld_type_i,
    input  logic [1:0]      byte_off_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = 8'(word_i >> {byte_off_i, 3'b000});
        // Halves only use the upper offset bit; misaligned halves trap upstream.
        half_v = 16'(word_i >> {byte_off_i[1], 4'b0000});
        unique case (ld_type_i)
            cLdB:    data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
            cLdH:    data_o = {{(XLEN-16){half_v[15]}}, half_v};
            cLdBu:   data_o = {{(XLEN-8){1'b0}}, byte_v};
            cLdHu:   data_o = {{(XLEN-16){1'b0}}, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/write_back.sv
// Final pipeline stage: registers one-cycle register-file write pulses and retire pulses.
// Define WB_INSTRET_EN to build the 64-bit retired-instruction counter on oInstret.
module write_back
    import write_back_pkg::*;
#(
    parameter int unsigned XLEN      = cXLEN,
    parameter int unsigned REG_SEL_W = cRegSelBitW
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iValid,
    output logic            oReady,
    input  tWbInfo          iWb,
    input  logic [XLEN-1:0] iAluRes,
    input  logic [XLEN-1:0] iPc4,
    input  logic            iLoadValid,
    input  logic [XLEN-1:0] iLoadData,
    output tRegControl      rdCntrl,
    output logic [XLEN-1:0] rdData,
    output logic            oRetire,
    output logic [63:0]     oInstret
);

    wb_state_e              state_q, state_d;
    logic                   wr_en_q, wr_en_d;
    logic [REG_SEL_W-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]        wr_data_q, wr_data_d;
    logic                   retire_q, retire_d;
    logic [REG_SEL_W-1:0]   hold_rd_q, hold_rd_d;
    logic [2:0]             hold_ld_q, hold_ld_d;
    logic [1:0]             hold_off_q, hold_off_d;
    logic [XLEN-1:0]        aligned;
    logic                   accept;

    write_back_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .word_i     (iLoadData),
        .ld_type_i  (hold_ld_q),
        .byte_off_i (hold_off_q),
        .data_o     (aligned)
    );

    assign oReady = (state_q == StIdle) && iRst;
    assign accept = iValid && oReady;

    always_comb begin
        state_d    = state_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        retire_d   = 1'b0;
        hold_rd_d  = hold_rd_q;
        hold_ld_d  = hold_ld_q;
        hold_off_d = hold_off_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (iWb.wbSel)
                        WB_ALU: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = iWb.rdAddr;
                            wr_data_d = iAluRes;
                            retire_d  = 1'b1;
                        end
                        WB_PC4: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = iWb.rdAddr;
                            wr_data_d = iPc4;
                            retire_d  = 1'b1;
                        end
                        WB_NONE: retire_d = 1'b1;
                        WB_LOAD: begin
                            hold_rd_d  = iWb.rdAddr;
                            hold_ld_d  = iWb.ldType;
                            hold_off_d = iWb.byteOff;
                            state_d    = StWaitLoad;
                        end
                    endcase
                end
            end
            StWaitLoad: begin
                if (iLoadValid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = hold_rd_q;
                    wr_data_d = aligned;
                    retire_d  = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // x0 is hardwired: data still tracks, but no write strobe
        if (wr_addr_d == '0) begin
            wr_en_d = 1'b0;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q    <= StIdle;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            retire_q   <= 1'b0;
            hold_rd_q  <= '0;
            hold_ld_q  <= '0;
            hold_off_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            retire_q   <= retire_d;
            hold_rd_q  <= hold_rd_d;
            hold_ld_q  <= hold_ld_d;
            hold_off_q <= hold_off_d;
        end
    end

    assign rdCntrl.en   = wr_en_q;
    assign rdCntrl.addr = wr_addr_q;
    assign rdData       = wr_data_q;
    assign oRetire      = retire_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            instret_q <= '0;
        end else if (retire_q) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign oInstret = instret_q;
`else
    assign oInstret = '0;
`endif

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: a scoreboard queue holds expected write
// pulses, popped by a monitor whenever oRetire fires.
module tb_write_back;
    import write_back_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        ready;
    tWbInfo      wb;
    logic [31:0] alu_res;
    logic [31:0] pc4;
    logic        ld_valid;
    logic [31:0] ld_data;
    tRegControl  rd_ctrl;
    logic [31:0] rd_data;
    logic        retire;
    logic [63:0] instret;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    write_back dut (
        .iClk       (clk),
        .iRst       (rst),
        .iValid     (valid),
        .oReady     (ready),
        .iWb        (wb),
        .iAluRes    (alu_res),
        .iPc4       (pc4),
        .iLoadValid (ld_valid),
        .iLoadData  (ld_data),
        .rdCntrl    (rd_ctrl),
        .rdData     (rd_data),
        .oRetire    (retire),
        .oInstret   (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: every retire must match the oldest expectation.
    always @(negedge clk) begin
        if (retire === 1'b1) begin
            n_tests++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_retire: got en=%b addr=%0d data=%h, required no retire",
                         rd_ctrl.en, rd_ctrl.addr, rd_data);
            end else begin
                mon_e = expq.pop_front();
                if (rd_ctrl.en !== mon_e.en || (mon_e.en && rd_ctrl.addr !== mon_e.addr) ||
                    (mon_e.chk_data && rd_data !== mon_e.data)) begin
                    n_fail++;
                    $display("FAIL wb_pulse: got en=%b addr=%0d data=%h, required en=%b addr=%0d data=%h",
                             rd_ctrl.en, rd_ctrl.addr, rd_data, mon_e.en, mon_e.addr, mon_e.data);
                end
            end
        end else if (rd_ctrl.en === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL en_without_retire: got en=1 retire=%b, required en=0", retire);
        end
    end

    task automatic push_exp(input logic en, input logic [4:0] addr, input logic [31:0] data,
                            input logic chk);
        exp_t e;
        e.en = en; e.addr = addr; e.data = data; e.chk_data = chk;
        expq.push_back(e);
    endtask

    // Call at posedge+1; presents one instruction for exactly one edge.
    task automatic accept(input tWbSel sel, input logic [4:0] rd, input logic [2:0] lt,
                          input logic [1:0] off, input logic [31:0] a, input logic [31:0] p);
        valid = 1'b1;
        wb.rdAddr = rd; wb.wbSel = sel; wb.ldType = lt; wb.byteOff = off;
        alu_res = a; pc4 = p;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && expq.size() > 0; i++) @(negedge clk);
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending pulses, required 0", name, expq.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [2:0] lt, input logic [1:0] off,
                           input logic [31:0] word, input logic [31:0] exp_data, input string name);
        accept(WB_LOAD, rd, lt, off, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_wait_ready: got %b, required 0 (cycle %0d)", name, ready, i);
            end
        end
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_data = word;
        push_exp(1'b1, rd, exp_data, 1'b1);
        @(posedge clk); #1;
        ld_valid = 1'b0;
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_after: got %b, required 1", name, ready);
        end
        wait_drain(name);
    endtask

    task automatic test_reset();
        rst = 1'b0; valid = 1'b0; ld_valid = 1'b0; ld_data = '0;
        wb = '0; alu_res = '0; pc4 = '0;
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 0", ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rd_ctrl !== '0 || rd_data !== '0 || retire !== 1'b0 || instret !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctrl=%h data=%h retire=%b instret=%0d, required all 0",
                     rd_ctrl, rd_data, retire, instret);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", ready);
        end
    endtask

    task automatic test_alu();
        push_exp(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        accept(WB_ALU, 5'd5, 3'b0, 2'b0, 32'hDEADBEEF, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (rd_ctrl.en !== 1'b0 || retire !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_pulse_width: got en=%b retire=%b, required 0 0", rd_ctrl.en, retire);
        end
        @(posedge clk); #1;
        push_exp(1'b1, 5'd4, 32'h00001004, 1'b1);
        accept(WB_PC4, 5'd4, 3'b0, 2'b0, 32'h5555AAAA, 32'h00001004);
        wait_drain("alu_pc4");
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            n_tests++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready: got %b, required 1 (beat %0d)", ready, i);
            end
            valid = 1'b1;
            wb.rdAddr = 5'(i); wb.wbSel = WB_ALU; wb.ldType = 3'b0; wb.byteOff = 2'b0;
            alu_res = 32'(i);
            push_exp(1'b1, 5'(i), 32'(i), 1'b1);
            @(posedge clk); #1;
        end
        valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (retire !== 1'b1 || rd_data !== 32'd3) begin
            n_fail++;
            $display("FAIL b2b_third_pulse: got retire=%b data=%h, required 1 00000003", retire, rd_data);
        end
        @(posedge clk); #1;
        wait_drain("b2b");
    endtask

    task automatic test_loads();
        do_load(5'd7,  cLdB,  2'd2, 32'h12805634, 32'hFFFFFF80, "lb");
        do_load(5'd8,  cLdBu, 2'd2, 32'h12805634, 32'h00000080, "lbu");
        do_load(5'd10, cLdHu, 2'd2, 32'hABCD1234, 32'h0000ABCD, "lhu");
        do_load(5'd11, cLdH,  2'd2, 32'hABCD1234, 32'hFFFFABCD, "lh");
        do_load(5'd12, 3'b011, 2'd3, 32'hCAFEF00D, 32'hCAFEF00D, "lw_alias");
    endtask

    task automatic test_x0_none();
        logic [63:0] base;
        repeat (2) @(posedge clk);
        #1;
        base = instret;
        push_exp(1'b0, 5'd0, 32'h00000055, 1'b1);
        accept(WB_ALU, 5'd0, 3'b0, 2'b0, 32'h00000055, 32'h0);
        push_exp(1'b0, 5'd0, 32'h0, 1'b0);
        accept(WB_NONE, 5'd9, 3'b0, 2'b0, 32'h11111111, 32'h0);
        wait_drain("x0_none");
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
`ifdef WB_INSTRET_EN
        if (instret - base !== 64'd2) begin
            n_fail++;
            $display("FAIL instret_delta: got %0d, required 2", instret - base);
        end
`else
        if (instret !== 64'd0 || base !== 64'd0) begin
            n_fail++;
            $display("FAIL instret_tied: got %0d, required 0", instret);
        end
`endif
    endtask

    task automatic test_reset_mid_load();
        accept(WB_LOAD, 5'd9, cLdW, 2'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rml_ready_in_reset: got %b, required 0", ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (ready !== 1'b1 || instret !== 64'd0) begin
            n_fail++;
            $display("FAIL rml_after_release: got ready=%b instret=%0d, required 1 0", ready, instret);
        end
        @(posedge clk); #1;
        ld_valid = 1'b1; ld_data = 32'h87654321;
        @(posedge clk); #1;
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (retire !== 1'b0 || rd_ctrl.en !== 1'b0) begin
                n_fail++;
                $display("FAIL rml_no_write: got retire=%b en=%b, required 0 0", retire, rd_ctrl.en);
            end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_alu();
        test_back_to_back();
        test_loads();
        test_x0_none();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
